// File: rtl/sdram_write.sv
// sdram_write: single-burst SDRAM write controller.
// Writes one 128-bit word as an 8-beat x16 burst with auto-precharge.
module sdram_write #(
    parameter int unsigned POST_WAIT = 4
) (
    input  logic         iclk,
    input  logic         ireset_n,
    input  logic         ireq,
    input  logic         ienb,
    output logic         ofin,
    input  logic [12:0]  irow,
    input  logic [9:0]   icolumn,
    input  logic [1:0]   ibank,
    input  logic [127:0] idata,
    output logic         DRAM_CLK,
    output logic         DRAM_CKE,
    output logic [12:0]  DRAM_ADDR,
    output logic [1:0]   DRAM_BA,
    output logic         DRAM_CS_N,
    output logic         DRAM_RAS_N,
    output logic         DRAM_CAS_N,
    output logic         DRAM_WE_N,
    output logic         DRAM_LDQM,
    output logic         DRAM_UDQM,
    inout  wire  [15:0]  DRAM_DQ
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_NOP_RCD,
        S_WRITE,
        S_BURST,
        S_WAIT,
        S_FIN
    } state_e;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] PW_LAST = 4'(POST_WAIT);

    state_e         state_q, state_d;
    logic [12:0]    row_q, row_d;
    logic [9:0]     col_q, col_d;
    logic [1:0]     bank_q, bank_d;
    logic [127:0]   data_q, data_d;
    logic [2:0]     beat_q, beat_d;
    logic [3:0]     wait_q, wait_d;
    logic [3:0]     cmd_q, cmd_d;
    logic [12:0]    addr_q, addr_d;
    logic [1:0]     ba_q, ba_d;
    logic [1:0]     dqm_q, dqm_d;
    logic [15:0]    dq_q, dq_d;
    logic           dq_oe_q, dq_oe_d;
    logic           ofin_q, ofin_d;

    // State register.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request, counters and registered pin values.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            row_q   <= '0;
            col_q   <= '0;
            bank_q  <= '0;
            data_q  <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            ba_q    <= '0;
            dqm_q   <= 2'b11;
            dq_q    <= '0;
            dq_oe_q <= 1'b0;
            ofin_q  <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            bank_q  <= bank_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ba_q    <= ba_d;
            dqm_q   <= dqm_d;
            dq_q    <= dq_d;
            dq_oe_q <= dq_oe_d;
            ofin_q  <= ofin_d;
        end
    end

    // Next state; pins are registered from the current state, so they
    // trail the state by one cycle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        bank_d  = bank_q;
        data_d  = data_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        cmd_d   = CMD_NOP;
        addr_d  = '0;
        ba_d    = '0;
        dqm_d   = 2'b11;
        dq_d    = '0;
        dq_oe_d = 1'b0;
        ofin_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ireq) begin
                    row_d   = irow;
                    col_d   = icolumn;
                    bank_d  = ibank;
                    data_d  = idata;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                cmd_d   = CMD_ACT;
                addr_d  = row_q;
                ba_d    = bank_q;
                state_d = S_NOP_RCD;
            end
            S_NOP_RCD: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                cmd_d   = CMD_WR;
                addr_d  = {3'b001, col_q};
                ba_d    = bank_q;
                dqm_d   = 2'b00;
                dq_d    = data_q[127:112];
                dq_oe_d = 1'b1;
                data_d  = {data_q[111:0], 16'h0000};
                beat_d  = 3'd1;
                state_d = S_BURST;
            end
            S_BURST: begin
                dqm_d   = 2'b00;
                dq_d    = data_q[127:112];
                dq_oe_d = 1'b1;
                data_d  = {data_q[111:0], 16'h0000};
                if (beat_q == 3'd7) begin
                    wait_d  = 4'd1;
                    state_d = S_WAIT;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (wait_q == PW_LAST) begin
                    state_d = S_FIN;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_FIN: begin
                ofin_d  = 1'b1;
                beat_d  = '0;
                wait_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ofin = ofin_q;

    // The grant only gates the pins; the sequencer keeps running.
    assign DRAM_CLK   = ienb ? ~iclk     : 1'bz;
    assign DRAM_CKE   = ienb ? 1'b1      : 1'bz;
    assign DRAM_ADDR  = ienb ? addr_q    : 13'bz;
    assign DRAM_BA    = ienb ? ba_q      : 2'bz;
    assign DRAM_CS_N  = ienb ? cmd_q[3]  : 1'bz;
    assign DRAM_RAS_N = ienb ? cmd_q[2]  : 1'bz;
    assign DRAM_CAS_N = ienb ? cmd_q[1]  : 1'bz;
    assign DRAM_WE_N  = ienb ? cmd_q[0]  : 1'bz;
    assign DRAM_LDQM  = ienb ? dqm_q[0]  : 1'bz;
    assign DRAM_UDQM  = ienb ? dqm_q[1]  : 1'bz;
    assign DRAM_DQ    = (ienb && dq_oe_q) ? dq_q : 16'bz;

endmodule

// File: doc/sdram_write.md
# sdram_write

Single-burst SDRAM write controller: on request, writes one 128-bit word as an 8-beat x16 burst to a given bank/row/column, then returns to idle. It is the write-side counterpart of the SDRAM read controller and shares the same DRAM pin bus behind the memory arbiter, which selects the active master via `ienb`. Beat order matches the read controller (first beat = bits [127:112]), so a read of a written location returns the identical 128-bit value.

## Interface
- `POST_WAIT`, 4: NOP cycles after the last data beat, covering tWR + tRP of auto-precharge; legal range 1..15.

- `iclk`  in  1  system clock; all logic on rising edge.
- `ireset_n`  in  1  asynchronous, active-low reset.
- `ireq`  in  1  start request; sampled in IDLE only.
- `ienb`  in  1  bus grant; when low, every DRAM_* output is high-Z.
- `ofin`  out  1  one-cycle pulse: burst written and bank precharged.
- `irow`  in  13  row address.
- `icolumn`  in  10  start column; burst aligned to 8, so [2:0] should be 0.
- `ibank`  in  2  bank.
- `idata`  in  128  write data.
- `DRAM_CLK`  out  1  `~iclk` when `ienb`.
- `DRAM_CKE`  out  1  1 when `ienb`.
- `DRAM_ADDR`  out  13  address.
- `DRAM_BA`  out  2  bank.
- `DRAM_CS_N`, `DRAM_RAS_N`, `DRAM_CAS_N`, `DRAM_WE_N`  out  1 each  command.
- `DRAM_LDQM`, `DRAM_UDQM`  out  1 each  byte masks.
- `DRAM_DQ`  inout  16  driven only while `ienb` and a data beat is active; otherwise high-Z.

## Operation
- Commands on {CS,RAS,CAS,WE}: NOP 0111, ACTIVE 0011, WRITE 0100. The mode register (burst length 8, sequential) is programmed by the init block, not here.
- At the IDLE edge where `ireq`=1, `irow`, `icolumn`, `ibank`, and `idata` are captured into registers. Input changes after capture have no effect.
- States: IDLE -> ACTIVE -> NOP_RCD -> WRITE -> BURST (7 beats) -> WAIT (POST_WAIT cycles) -> FIN -> IDLE.
- ACTIVE: ADDR=row, BA=bank, DQM=11.
- NOP_RCD: NOP, ADDR=0, BA=0, DQM=11.
- WRITE: ADDR={3'b001, column} (A10=1, auto-precharge), BA=bank, DQM=00, DQ=data[127:112].
- BURST: NOP, DQM=00. Each cycle the data register shifts left by 16 and DQ drives the top 16 bits, so beats 1..7 are [111:96] .. [15:0]. A 3-bit beat counter exits after beat 7.
- WAIT: NOP, DQM=11, DQ high-Z. A 4-bit counter runs POST_WAIT cycles.
- FIN: NOP, `ofin`=1 for exactly one cycle.
- All DRAM outputs are registered. `ienb` only gates the pins; the FSM runs regardless of `ienb`.
- `ireq` outside IDLE is ignored. `ireq` still high in the cycle after FIN starts a new burst with fresh capture.

## Timing
- Let edge T0 be the edge that samples `ireq`=1 in IDLE; "cycle k" is the clock period after edge T0+k.
- Pin sequence:
  - cycle 1: ACTIVE.
  - cycle 2: NOP.
  - cycle 3: WRITE with beat 0.
  - cycles 4..10: beats 1..7.
  - cycles 11..10+POST_WAIT: NOP, DQ high-Z.
  - cycle 11+POST_WAIT: `ofin`=1.
  - cycle 12+POST_WAIT: IDLE, and `ireq` is sampled again.
- tRCD = 2 cycles; write latency 0 (data with the WRITE command).
- Total request-to-`ofin` latency: 11+POST_WAIT edges (15 at default).
- Reset values (immediate on `ireset_n`=0, no clock needed):
  - state IDLE, command NOP, ADDR 0, BA 0, DQM 11.
  - `ofin` 0, DQ drive off, counters 0, data register 0.
- Reset mid-burst: abort at once, no further commands issued. The row may remain open; the system re-runs init after reset.
- `ireset_n` deassertion: first `ireq` sample at the first rising edge with `ireset_n`=1.

## Test plan
- Reset: assert `ireset_n`=0 mid-cycle with no clock -> command 0111, DQM 11, `ofin` 0, DQ high-Z, immediately.
- Basic write: `ienb`=1, row 0x0ABC, bank 2, column 0x010, `idata`=0x0001_0002_..._0008 (beats 0x0001..0x0008). Required:
  - cycle 1: ACTIVE with ADDR 0x0ABC, BA 2.
  - cycle 3: WRITE with ADDR 0x0410, DQ 0x0001.
  - cycles 4..10: DQ 0x0002..0x0008.
  - `ofin` at cycle 15.
- Input stability: change `idata`/`irow` one cycle after T0 -> pins still show the captured values.
- Back-to-back: hold `ireq`=1 -> second ACTIVE exactly 2 cycles after the first `ofin` pulse. Also `ireq` pulses during BURST -> ignored, a single `ofin`.
- Bus release: `ienb`=0 throughout the burst -> all DRAM_* high-Z, `ofin` still at cycle 15. With POST_WAIT=1, `ofin` at cycle 12.
- Abort: `ireset_n`=0 at cycle 6 -> DQ high-Z and NOP at once. After release, a new request completes normally, and a read controller loopback returns the written 128-bit word.
